// File: rtl/mod_arb_sequencer.sv
// ----------------------------------------------------------------------------
// mod_arb_sequencer
//   Round-robin arbiter for two requesters (A, B) that share one three-stage
//   modular add/subtract pipeline. Each operation computes (x + y) mod M or
//   (x - y) mod M. Operands >= M flag an error and produce a zero result, but
//   the operation still travels the pipeline like any other.
//
//   Pipeline:  S1 (captured request) -> S2 (5-bit intermediate + correction
//   flag) -> OUT (final residue). All stages shift together when
//   advance = !out_valid || out_ready, and all hold otherwise. Empty slots
//   (bubbles) shift like operations.
//
// Parameters
//   M          modulus, legal range 2..16
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   a_valid    requester A has an operation pending
//   a_ready    requester A operation accepted this cycle
//   a_s        requester A op: 0 = add, 1 = subtract
//   a_x, a_y   requester A operands (4 bit)
//   b_*        same as a_* for requester B
//   out_valid  result present on out_z / out_src / out_err
//   out_ready  consumer accepts the result this cycle
//   out_z      result residue
//   out_src    originating requester: 0 = A, 1 = B
//   out_err    at least one operand was >= M
//   busy       at least one pipeline stage holds a valid operation
// ----------------------------------------------------------------------------
module mod_arb_sequencer #(
   parameter int unsigned M = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic       a_s,
   input  logic [3:0] a_x,
   input  logic [3:0] a_y,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic       b_s,
   input  logic [3:0] b_x,
   input  logic [3:0] b_y,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_z,
   output logic       out_src,
   output logic       out_err,
   output logic       busy
);

   typedef enum logic {
      LAST_A = 1'b0,
      LAST_B = 1'b1
   } last_e;

   localparam logic [4:0] MOD = 5'(M);

   // last-grant register
   last_e      last_q, last_d;

   // S1: captured request
   logic       s1_valid_q, s1_valid_d;
   logic       s1_s_q,     s1_s_d;
   logic       s1_src_q,   s1_src_d;
   logic       s1_err_q,   s1_err_d;
   logic [3:0] s1_x_q,     s1_x_d;
   logic [3:0] s1_y_q,     s1_y_d;

   // S2: 5-bit intermediate plus correction flag
   logic       s2_valid_q, s2_valid_d;
   logic       s2_s_q,     s2_s_d;
   logic       s2_src_q,   s2_src_d;
   logic       s2_err_q,   s2_err_d;
   logic [4:0] s2_sum_q,   s2_sum_d;
   logic       s2_corr_q,  s2_corr_d;

   // OUT: final result
   logic       out_valid_q, out_valid_d;
   logic [3:0] out_z_q,     out_z_d;
   logic       out_src_q,   out_src_d;
   logic       out_err_q,   out_err_d;

   logic       advance;
   logic       grant_a;
   logic       grant_b;
   logic       req_s;
   logic [3:0] req_x;
   logic [3:0] req_y;
   logic [4:0] x5;
   logic [4:0] y5;
   logic [4:0] add5;
   logic [4:0] sub5;
   logic [4:0] fix5;

   // ------------------------------------------------------------------------
   // Arbitration and handshake
   // ------------------------------------------------------------------------
   always_comb begin
      advance = !out_valid_q || out_ready;
      grant_a = a_valid && (!b_valid || (last_q == LAST_B));
      grant_b = b_valid && (!a_valid || (last_q == LAST_A));
      // Readies are forced low during reset so nothing is handed over while
      // the pipeline is being flushed.
      a_ready = advance && grant_a && !rst;
      b_ready = advance && grant_b && !rst;

      req_s = grant_b ? b_s : a_s;
      req_x = grant_b ? b_x : a_x;
      req_y = grant_b ? b_y : a_y;
   end

   // ------------------------------------------------------------------------
   // Next-state: every stage shifts on advance, holds otherwise
   // ------------------------------------------------------------------------
   always_comb begin
      last_d      = last_q;

      s1_valid_d  = s1_valid_q;
      s1_s_d      = s1_s_q;
      s1_src_d    = s1_src_q;
      s1_err_d    = s1_err_q;
      s1_x_d      = s1_x_q;
      s1_y_d      = s1_y_q;

      s2_valid_d  = s2_valid_q;
      s2_s_d      = s2_s_q;
      s2_src_d    = s2_src_q;
      s2_err_d    = s2_err_q;
      s2_sum_d    = s2_sum_q;
      s2_corr_d   = s2_corr_q;

      out_valid_d = out_valid_q;
      out_z_d     = out_z_q;
      out_src_d   = out_src_q;
      out_err_d   = out_err_q;

      x5   = {1'b0, s1_x_q};
      y5   = {1'b0, s1_y_q};
      add5 = x5 + y5;
      sub5 = x5 - y5;
      // Correction: subtract M after an add that reached M, add M after a
      // subtract that borrowed. Low 4 bits of the 5-bit result are the residue.
      if (s2_corr_q) begin
         fix5 = s2_s_q ? (s2_sum_q + MOD) : (s2_sum_q - MOD);
      end else begin
         fix5 = s2_sum_q;
      end

      // priority only rotates on an actual transfer
      if (a_ready) begin
         last_d = LAST_A;
      end else if (b_ready) begin
         last_d = LAST_B;
      end

      if (advance) begin
         // S1 <- request (or bubble)
         s1_valid_d = a_ready || b_ready;
         s1_s_d     = req_s;
         s1_src_d   = grant_b;
         s1_err_d   = ({1'b0, req_x} >= MOD) || ({1'b0, req_y} >= MOD);
         s1_x_d     = req_x;
         s1_y_d     = req_y;

         // S2 <- intermediate
         s2_valid_d = s1_valid_q;
         s2_s_d     = s1_s_q;
         s2_src_d   = s1_src_q;
         s2_err_d   = s1_err_q;
         if (s1_err_q) begin
            s2_sum_d  = '0;
            s2_corr_d = 1'b0;
         end else if (s1_s_q) begin
            s2_sum_d  = sub5;
            s2_corr_d = (s1_x_q < s1_y_q);
         end else begin
            s2_sum_d  = add5;
            s2_corr_d = (add5 >= MOD);
         end

         // OUT <- corrected residue
         out_valid_d = s2_valid_q;
         out_src_d   = s2_src_q;
         out_err_d   = s2_err_q;
         out_z_d     = s2_err_q ? 4'd0 : fix5[3:0];
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q      <= LAST_B;
         s1_valid_q  <= 1'b0;
         s1_s_q      <= 1'b0;
         s1_src_q    <= 1'b0;
         s1_err_q    <= 1'b0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_s_q      <= 1'b0;
         s2_src_q    <= 1'b0;
         s2_err_q    <= 1'b0;
         s2_sum_q    <= '0;
         s2_corr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
         out_src_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         last_q      <= last_d;
         s1_valid_q  <= s1_valid_d;
         s1_s_q      <= s1_s_d;
         s1_src_q    <= s1_src_d;
         s1_err_q    <= s1_err_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s2_valid_q  <= s2_valid_d;
         s2_s_q      <= s2_s_d;
         s2_src_q    <= s2_src_d;
         s2_err_q    <= s2_err_d;
         s2_sum_q    <= s2_sum_d;
         s2_corr_q   <= s2_corr_d;
         out_valid_q <= out_valid_d;
         out_z_q     <= out_z_d;
         out_src_q   <= out_src_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_z     = out_z_q;
   assign out_src   = out_src_q;
   assign out_err   = out_err_q;
   assign busy      = s1_valid_q || s2_valid_q || out_valid_q;

endmodule

// File: tb/tb_mod_arb_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mod_arb_sequencer
//   Self-checking bench for mod_arb_sequencer (M = 13). The reference model is
//   an in-order queue of expected results; each entry counts the advancing
//   clock edges since acceptance and becomes the visible output once that
//   count reaches three. Results are computed with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_mod_arb_sequencer;

   localparam int unsigned M = 13;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, a_ready, a_s;
   logic [3:0] a_x, a_y;
   logic       b_valid, b_ready, b_s;
   logic [3:0] b_x, b_y;
   logic       out_valid, out_ready;
   logic [3:0] out_z;
   logic       out_src, out_err, busy;

   mod_arb_sequencer #(.M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_s       (a_s),
      .a_x       (a_x),
      .a_y       (a_y),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_s       (b_s),
      .b_x       (b_x),
      .b_y       (b_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_src   (out_src),
      .out_err   (out_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  z;
      logic        src;
      logic        err;
      int unsigned cnt;
   } exp_t;

   exp_t q[$];
   logic m_last;        // 0 = A granted last, 1 = B granted last

   int total = 0;
   int bad   = 0;

   // observations of the most recent drive_cycle
   logic       obs_ov, obs_src, obs_err, obs_busy, obs_ar, obs_br;
   logic [3:0] obs_z;

   function automatic exp_t ref_op(input logic s, input int x, input int y,
                                   input logic src);
      exp_t e;
      e.src = src;
      e.cnt = 1;
      e.err = (x >= M) || (y >= M);
      if (e.err)  e.z = 4'd0;
      else if (s) e.z = 4'((x - y + M) % M);
      else        e.z = 4'((x + y) % M);
      return e;
   endfunction

   // One clock cycle: sample registered outputs, drive inputs, check readies,
   // advance the model, then wait for the rising edge.
   task automatic drive_cycle(input logic av, input logic as_, input int ax,
                              input int ay, input logic bv, input logic bs_,
                              input int bx, input int by, input logic ord);
      logic adv, ga, gb, exp_ov;
      @(negedge clk);
      exp_ov   = (q.size() > 0) && (q[0].cnt == 3);
      obs_ov   = out_valid;
      obs_z    = out_z;
      obs_src  = out_src;
      obs_err  = out_err;
      obs_busy = busy;
      total++;
      if (out_valid !== exp_ov) begin
         bad++; $display("FAIL out_valid: got %b want %b", out_valid, exp_ov);
      end
      total++;
      if (busy !== (q.size() > 0)) begin
         bad++; $display("FAIL busy: got %b want %b", busy, q.size() > 0);
      end
      if (exp_ov) begin
         total++;
         if (out_z !== q[0].z || out_src !== q[0].src || out_err !== q[0].err) begin
            bad++;
            $display("FAIL result: got z=%0d src=%b err=%b want z=%0d src=%b err=%b",
                     out_z, out_src, out_err, q[0].z, q[0].src, q[0].err);
         end
      end

      rst = 1'b0;
      a_valid = av; a_s = as_; a_x = 4'(ax); a_y = 4'(ay);
      b_valid = bv; b_s = bs_; b_x = 4'(bx); b_y = 4'(by);
      out_ready = ord;
      #1;
      adv = !exp_ov || ord;
      ga  = av && (!bv || m_last);
      gb  = bv && (!av || !m_last);
      obs_ar = a_ready;
      obs_br = b_ready;
      total++;
      if (a_ready !== (adv && ga) || b_ready !== (adv && gb)) begin
         bad++;
         $display("FAIL ready: got a=%b b=%b want a=%b b=%b",
                  a_ready, b_ready, adv && ga, adv && gb);
      end

      if (adv) begin
         if (exp_ov) void'(q.pop_front());
         foreach (q[i]) q[i].cnt++;
         if (ga) begin
            q.push_back(ref_op(as_, ax, ay, 1'b0)); m_last = 1'b0;
         end else if (gb) begin
            q.push_back(ref_op(bs_, bx, by, 1'b1)); m_last = 1'b1;
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Holds rst over one rising edge with both requesters asserting.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
      #1;
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         bad++; $display("FAIL ready_in_reset: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      @(posedge clk);
      q.delete();
      m_last = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      total++;
      if ({out_valid, busy, out_z, out_src, out_err} !== 8'h00) begin
         bad++;
         $display("FAIL reset_state: got v=%b busy=%b z=%0d src=%b err=%b want all 0",
                  out_valid, busy, out_z, out_src, out_err);
      end
   endtask

   // Single operation, checked against hand-computed constants at cycle n+3.
   task automatic test_single_op(input logic isb, input logic s, input int x,
                                 input int y, input logic [3:0] ez,
                                 input logic eerr);
      if (isb) drive_cycle(0, 0, 0, 0, 1, s, x, y, 1);
      else     drive_cycle(1, s, x, y, 0, 0, 0, 0, 1);
      idle(2);
      #2;
      total++;
      if (out_valid !== 1'b1 || out_z !== ez || out_src !== isb || out_err !== eerr) begin
         bad++;
         $display("FAIL single_op x=%0d y=%0d s=%b: got v=%b z=%0d src=%b err=%b want v=1 z=%0d src=%b err=%b",
                  x, y, s, out_valid, out_z, out_src, out_err, ez, isb, eerr);
      end
      idle(2);
   endtask

   task automatic test_arbitration();
      logic [7:0] ar_seq, ov_seq, src_seq;
      do_reset();
      ar_seq = '0; ov_seq = '0; src_seq = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) drive_cycle(1, 0, i, 1, 1, 1, 12, i, 1);
         else       idle(1);
         ar_seq[i]  = obs_ar;
         ov_seq[i]  = obs_ov;
         src_seq[i] = obs_ov & obs_src;
      end
      total++;
      if (ar_seq[3:0] !== 4'b0101) begin
         bad++; $display("FAIL arb_grants: got a_ready seq %b want 0101", ar_seq[3:0]);
      end
      total++;
      if (ov_seq !== 8'b0111_1000 || src_seq !== 8'b0101_0000) begin
         bad++;
         $display("FAIL arb_src: got valid %b src %b want 01111000 01010000", ov_seq, src_seq);
      end
   endtask

   task automatic test_stall();
      logic [3:0] z0;
      logic       src0, err0;
      int         seen;
      drive_cycle(1, 0, 3, 4, 0, 0, 0, 0, 1);
      drive_cycle(1, 1, 1, 6, 0, 0, 0, 0, 1);
      drive_cycle(0, 0, 0, 0, 1, 0, 15, 2, 1);
      drive_cycle(1, 0, 5, 5, 1, 1, 5, 5, 0);
      z0 = obs_z; src0 = obs_src; err0 = obs_err;
      total++;
      if (obs_ov !== 1'b1 || obs_ar !== 1'b0 || obs_br !== 1'b0) begin
         bad++;
         $display("FAIL stall_first: got v=%b a_ready=%b b_ready=%b want 1 0 0",
                  obs_ov, obs_ar, obs_br);
      end
      drive_cycle(1, 0, 5, 5, 1, 1, 5, 5, 0);
      total++;
      if (obs_ov !== 1'b1 || obs_z !== z0 || obs_src !== src0 || obs_err !== err0
          || obs_ar !== 1'b0 || obs_br !== 1'b0) begin
         bad++;
         $display("FAIL stall_hold: got v=%b z=%0d src=%b err=%b want v=1 z=%0d src=%b err=%b",
                  obs_ov, obs_z, obs_src, obs_err, z0, src0, err0);
      end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         if (obs_ov) seen++;
      end
      total++;
      if (seen != 3) begin
         bad++; $display("FAIL stall_drain: got %0d results want 3", seen);
      end
   endtask

   task automatic test_reset_mid();
      drive_cycle(1, 0, 2, 2, 0, 0, 0, 0, 1);
      drive_cycle(0, 0, 0, 0, 1, 1, 7, 3, 1);
      do_reset();
      #2;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_mid: got v=%b busy=%b want 0 0", out_valid, busy);
      end
      drive_cycle(1, 0, 1, 1, 1, 0, 2, 2, 1);
      total++;
      if (obs_ar !== 1'b1 || obs_br !== 1'b0) begin
         bad++; $display("FAIL reset_mid_grant: got a=%b b=%b want 1 0", obs_ar, obs_br);
      end
      idle(5);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15), $urandom_range(0, 15),
                     ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 15), $urandom_range(0, 15),
                     ($urandom_range(0, 3) != 0));
      end
      idle(6);
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_s = 1'b0; a_x = '0; a_y = '0;
      b_valid = 1'b0; b_s = 1'b0; b_x = '0; b_y = '0;
      out_ready = 1'b1;
      m_last = 1'b1;

      test_reset();
      test_single_op(0, 0, 9, 7, 4'd3, 0);
      test_single_op(1, 1, 2, 5, 4'd10, 0);
      test_single_op(0, 0, 12, 12, 4'd11, 0);
      test_single_op(1, 1, 0, 0, 4'd0, 0);
      test_single_op(0, 0, 14, 3, 4'd0, 1);
      test_arbitration();
      test_stall();
      test_reset_mid();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_arb_sequencer.md
MOD_ARB_SEQUENCER -- requirements
Module: mod_arb_sequencer

Interface
REQ-001 The block SHALL have one parameter: M, default 13, modulus for all operations (legal range 2..16).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 a_valid  in  1  requester A has an operation pending.
REQ-006 a_ready  out  1  requester A operation accepted this cycle when a_valid=1.
REQ-007 a_s  in  1  requester A operation: 0 = add, 1 = subtract.
REQ-008 a_x, a_y  in  4 each  requester A operands.
REQ-009 b_valid, b_ready, b_s, b_x, b_y  same widths and meanings as the A ports, for requester B.
REQ-010 out_valid  out  1  result present on out_z/out_src/out_err.
REQ-011 out_ready  in  1  consumer accepts the result this cycle.
REQ-012 out_z  out  4  result residue.
REQ-013 out_src  out  1  originating requester: 0 = A, 1 = B.
REQ-014 out_err  out  1  at least one operand of this operation was >= M.
REQ-015 busy  out  1  at least one pipeline stage holds a valid operation.

Function
REQ-016 The block SHALL compute out_z = (x + y) mod M for s=0 and out_z = (x - y) mod M for s=1, with a 5-bit intermediate and a conditional +/-M correction; no other arithmetic is permitted.
REQ-017 If x >= M or y >= M, the block SHALL set out_err=1 and out_z=0 for that operation; it SHALL NOT drop the operation.
REQ-018 The pipeline SHALL have three registered stages: S1 (captured request), S2 (5-bit intermediate plus correction flag), OUT (final result); each stage carries a valid bit, s, src, and err.
REQ-019 Define advance = !out_valid || out_ready; when advance=1 all stages SHALL shift one position per cycle; when advance=0 all stages SHALL hold.
REQ-020 Bubbles SHALL shift like operations; there SHALL be no compaction.
REQ-021 An operation accepted in cycle n SHALL have out_valid=1 in cycle n+3 when advance=1 throughout; each stall cycle SHALL add exactly one cycle.
REQ-022 Throughput SHALL be one operation per cycle with out_ready held high.
REQ-023 Arbitration SHALL be round-robin with a 1-bit last-grant register.
REQ-024 Grant A if a_valid && (!b_valid || last==B); grant B if b_valid && (!a_valid || last==A).
REQ-025 a_ready = advance && grantA; b_ready = advance && grantB; at most one ready SHALL be high per cycle.
REQ-026 Ready signals MAY depend combinationally on the valid inputs and out_ready; valid inputs SHALL NOT be required to depend on ready.
REQ-027 last SHALL update only on an accepted transfer (valid && ready); a stall SHALL NOT rotate priority.
REQ-028 With a single requester valid, that requester SHALL be granted every advancing cycle regardless of last.
REQ-029 Results SHALL leave in acceptance order; no result SHALL be lost or duplicated across stalls.
REQ-030 out_z, out_src and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 busy SHALL be the OR of the S1, S2 and OUT valid bits.

Reset
REQ-032 While rst=1 at a clock edge, all stage valid bits SHALL clear and last SHALL be set to B, so A wins the first contested grant.
REQ-033 In the cycle after reset, out_valid=0 and busy=0; out_z=0, out_src=0, out_err=0.
REQ-034 Reset mid-operation SHALL discard all in-flight operations with no partial output.
REQ-035 a_ready and b_ready SHALL be 0 while rst=1.

Verification (M=13)
REQ-036 A: s=0, x=9, y=7, single cycle, out_ready=1 -> cycle n+3: out_valid=1, out_z=3, out_src=0, out_err=0.
REQ-037 B: s=1, x=2, y=5 -> out_z=10, out_src=1; boundary cases x=12,y=12 add -> 11 and x=0,y=0 sub -> 0.
REQ-038 A and B both valid for 4 cycles after reset -> grants A,B,A,B; out_src sequence 0,1,0,1 on consecutive cycles.
REQ-039 Three operations in flight, out_ready=0 for 2 cycles -> a_ready=b_ready=0 and out_* stable; all three results then emitted in order with no duplicates.
REQ-040 A: x=14, y=3, s=0 -> out_err=1, out_z=0, delivered with normal latency.
REQ-041 rst pulsed with two operations in flight -> next cycle out_valid=0, busy=0; the next contested request is granted to A.
